// File: rtl/matrix_mult_unit.sv
// matrix_mult_unit: capture-then-compute 4-element matrix multiplier; each result element wraps to 16 bits, or saturates to 0xFFFF when MATMUL_SATURATE_EN is defined
module matrix_mult_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] matrix_1,
  input  logic [63:0] matrix_2,
  input  logic [3:0]  R1,
  input  logic [3:0]  C1,
  input  logic [3:0]  R2,
  input  logic [3:0]  C2,
  input  logic        readybit,
  output logic [63:0] res_mat,
  output logic        res_valid,
  output logic        dim_err
);
`ifdef MATMUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d, prod;
  logic [3:0]  r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
  logic        pend_q, pend_d, valid_q, valid_d, err_q, err_d, legal;
  logic [15:0] ae [4];
  logic [15:0] be [4];
  logic [33:0] acc [4];
  logic [1:0]  ai, bi, ri;
  always_comb begin
    a_d = readybit ? matrix_1 : a_q;
    b_d = readybit ? matrix_2 : b_q;
    r1_d = readybit ? R1 : r1_q;
    c1_d = readybit ? C1 : c1_q;
    r2_d = readybit ? R2 : r2_q;
    c2_d = readybit ? C2 : c2_q;
    pend_d = readybit;
    legal = r1_q != 4'd0 && c1_q != 4'd0 && r2_q != 4'd0 && c2_q != 4'd0 && c1_q == r2_q
      && {4'd0, r1_q} * {4'd0, c1_q} <= 8'd4
      && {4'd0, r2_q} * {4'd0, c2_q} <= 8'd4
      && {4'd0, r1_q} * {4'd0, c2_q} <= 8'd4;
    ai = '0;
    bi = '0;
    ri = '0;
    prod = '0;
    for (int n = 0; n < 4; n++) begin
      ae[n] = a_q[48-16*n +: 16];
      be[n] = b_q[48-16*n +: 16];
      acc[n] = '0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          if (legal && 4'(i) < r1_q && 4'(j) < c2_q && 4'(k) < c1_q) begin
            ai = 2'(i * int'(c1_q) + k);
            bi = 2'(k * int'(c2_q) + j);
            ri = 2'(i * int'(c2_q) + j);
            acc[ri] = acc[ri] + {18'd0, ae[ai]} * {18'd0, be[bi]};
          end
    for (int n = 0; n < 4; n++)
      prod[48-16*n +: 16] = (SAT && |acc[n][33:16]) ? 16'hFFFF : acc[n][15:0];
    res_d = pend_q ? prod : res_q;
    err_d = pend_q ? !legal : err_q;
    valid_d = pend_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
      r1_q <= '0;
      c1_q <= '0;
      r2_q <= '0;
      c2_q <= '0;
      pend_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r1_q <= r1_d;
      c1_q <= c1_d;
      r2_q <= r2_d;
      c2_q <= c2_d;
      pend_q <= pend_d;
      res_q <= res_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
  assign res_mat = res_q;
  assign res_valid = valid_q;
  assign dim_err = err_q;
endmodule

// File: tb/tb_matrix_mult_unit.sv
// tb_matrix_mult_unit: directed vector table, hand sequences and random traffic against a spec-level matrix model
module tb_matrix_mult_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        readybit = 1'b0;
  logic [63:0] matrix_1 = '0, matrix_2 = '0;
  logic [3:0]  R1 = '0, C1 = '0, R2 = '0, C2 = '0;
  logic [63:0] res_mat;
  logic        res_valid, dim_err;
  int total = 0, bad = 0;
  typedef struct {
    string       name;
    logic [63:0] m1, m2;
    logic [3:0]  r1, c1, r2, c2;
    logic [63:0] er;
    logic        ee;
  } vec_t;
  vec_t tbl [8];
  matrix_mult_unit dut (
    .CLK(CLK), .RST(RST), .matrix_1(matrix_1), .matrix_2(matrix_2),
    .R1(R1), .C1(C1), .R2(R2), .C2(C2), .readybit(readybit),
    .res_mat(res_mat), .res_valid(res_valid), .dim_err(dim_err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic void model(input logic [63:0] m1, input logic [63:0] m2, input int r1, input int c1,
                                input int r2, input int c2, output logic [63:0] r, output logic e);
    longint s;
    bit ok;
    ok = r1 >= 1 && c1 >= 1 && r2 >= 1 && c2 >= 1 && c1 == r2 && r1 * c1 <= 4 && r2 * c2 <= 4 && r1 * c2 <= 4;
    r = '0;
    e = !ok;
    if (ok)
      for (int i = 0; i < r1; i++)
        for (int j = 0; j < c2; j++) begin
          s = 0;
          for (int k = 0; k < c1; k++)
            s += longint'(m1[63-16*(i*c1+k) -: 16]) * longint'(m2[63-16*(k*c2+j) -: 16]);
`ifdef MATMUL_SATURATE_EN
          if (s > 65535) s = 65535;
`endif
          r[63-16*(i*c2+j) -: 16] = s[15:0];
        end
  endfunction
  function automatic vec_t mk(input string n, input logic [63:0] m1, input logic [63:0] m2,
                              input logic [3:0] r1, input logic [3:0] c1, input logic [3:0] r2,
                              input logic [3:0] c2, input logic [63:0] er, input logic ee);
    vec_t t;
    t.name = n; t.m1 = m1; t.m2 = m2; t.r1 = r1; t.c1 = c1; t.r2 = r2; t.c2 = c2; t.er = er; t.ee = ee;
    return t;
  endfunction
  task automatic drive(input logic [63:0] m1, input logic [63:0] m2, input logic [3:0] r1,
                       input logic [3:0] c1, input logic [3:0] r2, input logic [3:0] c2, input logic rdy);
    matrix_1 = m1; matrix_2 = m2; R1 = r1; C1 = c1; R2 = r2; C2 = c2; readybit = rdy;
  endtask
  task automatic run_one(input vec_t t);
    @(negedge CLK);
    drive(t.m1, t.m2, t.r1, t.c1, t.r2, t.c2, 1'b1);
    @(negedge CLK);
    drive(~t.m1, ~t.m2, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    chk({t.name, " valid early"}, 64'(res_valid), 64'd0);
    @(negedge CLK);
    chk({t.name, " valid"}, 64'(res_valid), 64'd1);
    chk({t.name, " res"}, res_mat, t.er);
    chk({t.name, " err"}, 64'(dim_err), 64'(t.ee));
    @(negedge CLK);
    chk({t.name, " valid drop"}, 64'(res_valid), 64'd0);
    chk({t.name, " res hold"}, res_mat, t.er);
  endtask
  localparam logic [63:0] AM = 64'h0001_0002_0003_0004;
  logic [63:0] er, cm1, cm2, dm1, dm2;
  logic        ee, ev, crdy, drdy;
  logic [3:0]  cr1, cc1, cr2, cc2, dr1, dc1, dr2, dc2;
  initial begin
    tbl[0] = mk("2x2", AM, 64'h0005_0006_0007_0008, 2, 2, 2, 2, 64'h0013_0016_002B_0032, 0);
    tbl[1] = mk("dot", AM, 64'h0005_0006_0007_0008, 1, 4, 4, 1, 64'h0046_0000_0000_0000, 0);
    tbl[2] = mk("c1ne", AM, AM, 2, 2, 1, 2, 64'h0, 1);
    tbl[3] = mk("4x1x1x4", AM, AM, 4, 1, 1, 4, 64'h0, 1);
    tbl[4] = mk("r1zero", AM, AM, 0, 1, 1, 1, 64'h0, 1);
`ifdef MATMUL_SATURATE_EN
    tbl[5] = mk("ovf", 64'hFFFF_1111_2222_3333, 64'hFFFF_4444_5555_6666, 1, 1, 1, 1, 64'hFFFF_0000_0000_0000, 0);
`else
    tbl[5] = mk("ovf", 64'hFFFF_1111_2222_3333, 64'hFFFF_4444_5555_6666, 1, 1, 1, 1, 64'h0001_0000_0000_0000, 0);
`endif
    tbl[6] = mk("2x2x2x1", AM, 64'h0005_0006_0000_0000, 2, 2, 2, 1, 64'h0011_0027_0000_0000, 0);
    tbl[7] = mk("2x1x1x2", 64'h0002_0003_0000_0000, 64'h0004_0005_0000_0000, 2, 1, 1, 2, 64'h0008_000A_000C_000F, 0);
    repeat (2) @(negedge CLK);
    chk("reset res", res_mat, 64'h0);
    chk("reset valid", 64'(res_valid), 64'd0);
    chk("reset err", 64'(dim_err), 64'd0);
    RST = 1'b0;
    foreach (tbl[n]) run_one(tbl[n]);
    @(negedge CLK);
    drive(AM, 64'h0001_0000_0000_0001, 2, 2, 2, 2, 1'b1);
    @(negedge CLK);
    chk("b2b idle", 64'(res_valid), 64'd0);
    drive(AM, 64'h0000_0001_0001_0000, 2, 2, 2, 2, 1'b1);
    @(negedge CLK);
    chk("b2b ident valid", 64'(res_valid), 64'd1);
    chk("b2b ident", res_mat, AM);
    drive(AM, 64'h0, 2, 2, 2, 2, 1'b1);
    @(negedge CLK);
    chk("b2b swap valid", 64'(res_valid), 64'd1);
    chk("b2b swap", res_mat, 64'h0002_0001_0004_0003);
    readybit = 1'b0;
    @(negedge CLK);
    chk("b2b zero valid", 64'(res_valid), 64'd1);
    chk("b2b zero", res_mat, 64'h0);
    chk("b2b zero err", 64'(dim_err), 64'd0);
    @(negedge CLK);
    chk("b2b end", 64'(res_valid), 64'd0);
    run_one(tbl[0]);
    @(negedge CLK);
    drive(AM, 64'h0005_0006_0007_0008, 1, 4, 4, 1, 1'b1);
    @(negedge CLK);
    readybit = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst drop valid", 64'(res_valid), 64'd0);
    chk("rst drop res", res_mat, 64'h0);
    chk("rst drop err", 64'(dim_err), 64'd0);
    @(negedge CLK);
    chk("rst stays", 64'(res_valid), 64'd0);
    run_one(tbl[1]);
    @(negedge CLK);
    RST = 1'b1;
    readybit = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    er = '0; ee = 1'b0; ev = 1'b0; crdy = 1'b0; drdy = 1'b0;
    cm1 = '0; cm2 = '0; cr1 = '0; cc1 = '0; cr2 = '0; cc2 = '0;
    dm1 = '0; dm2 = '0; dr1 = '0; dc1 = '0; dr2 = '0; dc2 = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK);
      ev = crdy;
      if (crdy) model(cm1, cm2, cr1, cc1, cr2, cc2, er, ee);
      chk("rand valid", 64'(res_valid), 64'(ev));
      chk("rand res", res_mat, er);
      chk("rand err", 64'(dim_err), 64'(ee));
      crdy = drdy; cm1 = dm1; cm2 = dm2; cr1 = dr1; cc1 = dc1; cr2 = dr2; cc2 = dc2;
      for (int n = 0; n < 4; n++)
        dm1[16*n +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      for (int n = 0; n < 4; n++)
        dm2[16*n +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 300));
      dr1 = 4'($urandom_range(0, 4));
      dc1 = 4'($urandom_range(0, 4));
      dr2 = ($urandom_range(0, 9) < 7) ? dc1 : 4'($urandom_range(0, 4));
      dc2 = 4'($urandom_range(0, 4));
      drdy = $urandom_range(0, 3) != 0;
      drive(dm1, dm2, dr1, dc1, dr2, dc2, drdy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
